frac_clk_gen: RTL and testbench
===============================

FRAC_CLK_GEN -- requirements
Module: frac_clk_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent clock-enable channels (1..8).
REQ-002 SHALL have parameter ACC_W, default 24, phase-accumulator width in bits (8..32).
REQ-003 SHALL have parameter INIT_INC, default 0, increment loaded into every channel at reset.
REQ-004 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port sync_req  input  1  one-cycle request to phase-align all channels.
REQ-007 SHALL have port cfg_valid  input  1  increment write request.
REQ-008 SHALL have port cfg_ready  output  1  increment write can be accepted.
REQ-009 SHALL have port cfg_chan  input  3  target channel of the write.
REQ-010 SHALL have port cfg_inc  input  ACC_W  new increment value.
REQ-011 SHALL have port ce  output  CHANNELS  per-channel one-cycle clock-enable pulses.
REQ-012 SHALL have port clk_sq  output  CHANNELS  per-channel square wave, see REQ-027.
REQ-013 SHALL have port locked  output  CHANNELS  per-channel flag: nonzero increment active and no update pending.

Function
REQ-014 SHALL keep, per channel, an accumulator acc[ACC_W-1:0], an active increment inc, a pending increment and a pending flag.
REQ-015 Each cycle, each channel SHALL compute {carry, sum} = acc + inc in ACC_W+1 bits, then write sum to acc; wrap-around is modulo 2^ACC_W.
REQ-016 ce[ch] SHALL be registered and SHALL be high in the cycle after the add that produced carry=1, so latency is 1 clock.
REQ-017 The average ce rate SHALL be f_clk*inc/2^ACC_W, with no cumulative drift; the remainder stays in acc.
REQ-018 A write SHALL be accepted in a cycle where cfg_valid and cfg_ready are both high.
REQ-019 cfg_ready SHALL equal NOT pending[cfg_chan] combinationally; it SHALL be 1 when cfg_chan >= CHANNELS.
REQ-020 An accepted write to cfg_chan >= CHANNELS SHALL be dropped with no state change.
REQ-021 An accepted write SHALL store cfg_inc in the pending register and set the pending flag.
REQ-022 A pending increment SHALL become active in the cycle the channel's add produces carry=1; the next add uses the new inc, and acc keeps the remainder (glitch-free retune at the period boundary).
REQ-023 If the active inc is 0, a pending increment SHALL become active on the cycle after acceptance, because no carry would ever occur.
REQ-024 If a write is accepted in the same cycle as that channel's carry, the write SHALL stay pending until the next carry; the current carry does not consume it.
REQ-025 When sync_req=1, every acc SHALL load 0, every pending increment SHALL become active, every pending flag SHALL clear, and no ce SHALL be generated from that cycle's add.
REQ-026 Priority SHALL be: rst_n low, then sync_req, then normal add/update.
REQ-027 clk_sq[ch] SHALL toggle in the same cycle ce[ch] is high, giving f_ce/2 with a duty cycle only as even as the ce spacing.
REQ-028 locked[ch] SHALL be registered and SHALL equal (inc!=0 && !pending).

Reset
REQ-029 While rst_n is low at a clk edge: acc=0, inc=INIT_INC, pending flags=0, ce=0, clk_sq=0, locked=(INIT_INC!=0).
REQ-030 Reset mid-operation SHALL discard pending writes, with no ce pulse in the cycle after reset is released.
REQ-031 cfg_ready SHALL read 1 during and immediately after reset.

Configuration
REQ-032 With macro FRAC_CLK_SQUARE_EN defined, the clk_sq toggle flops of REQ-027 SHALL be built.
REQ-033 Without FRAC_CLK_SQUARE_EN, clk_sq SHALL be tied to 0 and no toggle flops are inferred; all other behaviour is unchanged.

Verification
REQ-034 ACC_W=8, CHANNELS=2, write ch0 inc=64 after reset -> ce[0] every 4th cycle, locked[0]=1 once active, ce[1]=0.
REQ-035 ch0 inc=96 -> ce[0] gaps repeat 3,3,2 (3 pulses per 8 cycles), and acc returns to 0 every 8 cycles.
REQ-036 ch0 running inc=64, write inc=128 mid-period -> cfg_ready[ch0]=0 and locked=0 until the next ce; afterwards ce every 2 cycles, with no short or double pulse at the switch.
REQ-037 ch0 inc=64 and ch1 inc=32, pulse sync_req -> both accs=0 and no ce that cycle; the first ce appears 4 and 8 cycles later respectively.
REQ-038 Write to cfg_chan=5 -> accepted with cfg_ready=1 and no state change; a write at the same cycle as a ch0 carry is applied only at the following carry.
REQ-039 Assert rst_n=0 while a write is pending, then release -> all outputs at reset values, pending lost, and the build with FRAC_CLK_SQUARE_EN undefined shows clk_sq constant 0.

Source files
------------

// File: rtl/frac_clk_gen.sv
// frac_clk_gen: multi-channel fractional clock-enable generator.
// Each channel adds its increment into a phase accumulator every clock; the
// carry out of that add becomes a registered one-cycle clock-enable pulse, so
// the average pulse rate is f_clk*inc/2^ACC_W with the remainder kept in acc.
// New increments wait in a per-channel pending register and take effect at
// the channel's next carry, which keeps retuning glitch-free.
// Build option: define FRAC_CLK_SQUARE_EN to build the clk_sq toggle flops;
// without it clk_sq is tied low.
module frac_clk_gen #(
    parameter int          CHANNELS = 2,
    parameter int          ACC_W    = 24,
    parameter int unsigned INIT_INC = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sync_req,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_chan,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic [CHANNELS-1:0] ce,
    output logic [CHANNELS-1:0] clk_sq,
    output logic [CHANNELS-1:0] locked
);

    localparam logic [ACC_W-1:0] INIT_INC_W = ACC_W'(INIT_INC);

    // Per-channel state
    logic [ACC_W-1:0]    acc_q      [CHANNELS];
    logic [ACC_W-1:0]    inc_q      [CHANNELS];
    logic [ACC_W-1:0]    pend_inc_q [CHANNELS];
    logic [CHANNELS-1:0] pend_q;
    logic [CHANNELS-1:0] ce_q;
    logic [CHANNELS-1:0] locked_q;

    // Next-state values
    logic [ACC_W-1:0]    acc_nxt      [CHANNELS];
    logic [ACC_W-1:0]    inc_nxt      [CHANNELS];
    logic [ACC_W-1:0]    pend_inc_nxt [CHANNELS];
    logic [CHANNELS-1:0] pend_nxt;
    logic [CHANNELS-1:0] ce_nxt;
    logic [CHANNELS-1:0] locked_nxt;
    logic [CHANNELS-1:0] wr_sel;
    logic [ACC_W:0]      sum;

    // Ready follows the addressed channel's pending flag; unmapped channels always accept.
    always_comb begin
        // NOTE: assign a default before any conditional so no path leaves the
        // output unassigned, which would infer a latch.
        cfg_ready = 1'b1;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (32'(cfg_chan) == ch) begin
                cfg_ready = ~pend_q[ch];
            end
        end
    end

    // Decode which channel (if any) takes the accepted write; unmapped writes select none.
    always_comb begin
        wr_sel = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            wr_sel[ch] = cfg_valid && cfg_ready && (32'(cfg_chan) == ch);
        end
    end

    // Phase add, pending-increment promotion and sync handling for every channel.
    always_comb begin
        sum        = '0;
        pend_nxt   = pend_q;
        ce_nxt     = '0;
        locked_nxt = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            acc_nxt[ch]      = acc_q[ch];
            inc_nxt[ch]      = inc_q[ch];
            pend_inc_nxt[ch] = pend_inc_q[ch];
            sum              = {1'b0, acc_q[ch]} + {1'b0, inc_q[ch]};

            if (sync_req) begin
                // Phase-align: restart from zero with any pending increment applied.
                acc_nxt[ch] = '0;
                if (pend_q[ch]) begin
                    inc_nxt[ch] = pend_inc_q[ch];
                end
                pend_nxt[ch] = 1'b0;
            end else begin
                acc_nxt[ch] = sum[ACC_W-1:0];
                ce_nxt[ch]  = sum[ACC_W];
                // Swap at the period boundary; an idle channel (inc 0) never
                // carries, so it takes the new value straight away.
                if (pend_q[ch] && (sum[ACC_W] || (inc_q[ch] == '0))) begin
                    inc_nxt[ch]  = pend_inc_q[ch];
                    pend_nxt[ch] = 1'b0;
                end
            end

            // A write lands only when nothing is pending, so it never collides
            // with a promotion and always waits for a later carry.
            if (wr_sel[ch]) begin
                pend_nxt[ch]     = 1'b1;
                pend_inc_nxt[ch] = cfg_inc;
            end

            locked_nxt[ch] = (inc_nxt[ch] != '0) && !pend_nxt[ch];
        end
    end

    // Channel state registers; reset overrides sync_req and the normal update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: these are a handful of per-channel flops, not a RAM, so
            // resetting every entry is intended.
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc_q[ch]      <= '0;
                inc_q[ch]      <= INIT_INC_W;
                pend_inc_q[ch] <= '0;
            end
            pend_q   <= '0;
            ce_q     <= '0;
            locked_q <= {CHANNELS{INIT_INC_W != '0}};
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same
            // pre-edge values.
            acc_q      <= acc_nxt;
            inc_q      <= inc_nxt;
            pend_inc_q <= pend_inc_nxt;
            pend_q     <= pend_nxt;
            ce_q       <= ce_nxt;
            locked_q   <= locked_nxt;
        end
    end

    assign ce     = ce_q;
    assign locked = locked_q;

`ifdef FRAC_CLK_SQUARE_EN
    logic [CHANNELS-1:0] sq_q;

    // Toggle each square wave in the same cycle its ce pulse is presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_q ^ ce_nxt;
        end
    end

    assign clk_sq = sq_q;
`else
    assign clk_sq = '0;
`endif

endmodule

// File: tb/tb_frac_clk_gen.sv
// tb_frac_clk_gen: self-checking bench for frac_clk_gen (CHANNELS=2, ACC_W=8).
// Directed vector table, hand-written corner sequences, then randomized
// traffic compared every cycle against an integer-arithmetic reference model.
module tb_frac_clk_gen;

    localparam int CH   = 2;
    localparam int W    = 8;
    localparam int MOD  = 1 << W;
    localparam int INIT = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sync_req;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_chan;
    logic [W-1:0]  cfg_inc;
    logic [CH-1:0] ce;
    logic [CH-1:0] clk_sq;
    logic [CH-1:0] locked;

    frac_clk_gen #(
        .CHANNELS(CH),
        .ACC_W   (W),
        .INIT_INC(INIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_req (sync_req),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_inc  (cfg_inc),
        .ce       (ce),
        .clk_sq   (clk_sq),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    logic ready_s;

    // Reference model state: plain integers, one entry per channel.
    int      m_acc  [CH];
    int      m_inc  [CH];
    int      m_pinc [CH];
    bit      m_pend [CH];
    bit [CH-1:0] m_ce;
    bit [CH-1:0] m_sq;
    bit [CH-1:0] m_locked;
    bit      model_valid = 1'b0;

    typedef struct {
        int sync;
        int valid;
        int chan;
        int inc;
        int exp_ready;
        int exp_ce;
        int exp_locked;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the behavioural model, from the rules for add, carry, retune and sync.
    task automatic model_step(input bit rst, input bit sync, input bit valid,
                              input int chan, input int inc);
        bit accept;
        int total;
        accept = valid && !rst && (chan < CH) && !m_pend[chan];
        for (int ch = 0; ch < CH; ch++) begin
            if (rst) begin
                m_acc[ch]  = 0;
                m_inc[ch]  = INIT;
                m_pinc[ch] = 0;
                m_pend[ch] = 1'b0;
                m_ce[ch]   = 1'b0;
                m_sq[ch]   = 1'b0;
            end else if (sync) begin
                m_acc[ch] = 0;
                if (m_pend[ch]) m_inc[ch] = m_pinc[ch];
                m_pend[ch] = 1'b0;
                m_ce[ch]   = 1'b0;
            end else begin
                total     = m_acc[ch] + m_inc[ch];
                m_ce[ch]  = (total >= MOD);
                m_acc[ch] = total % MOD;
                if (m_pend[ch] && (m_ce[ch] || m_inc[ch] == 0)) begin
                    m_inc[ch]  = m_pinc[ch];
                    m_pend[ch] = 1'b0;
                end
                if (m_ce[ch]) m_sq[ch] = ~m_sq[ch];
            end
            if (accept && chan == ch) begin
                m_pend[ch] = 1'b1;
                m_pinc[ch] = inc % MOD;
            end
            m_locked[ch] = (m_inc[ch] != 0) && !m_pend[ch];
        end
    endtask

    // Drive one cycle, sample cfg_ready before the edge and registered outputs 1ns after.
    task automatic cycle(input int rst, input int sync, input int valid, input int chan, input int inc);
        bit          exp_ready;
        bit [CH-1:0] exp_sq;
        rst_n     = (rst == 0);
        sync_req  = (sync != 0);
        cfg_valid = (valid != 0);
        cfg_chan  = 3'(chan);
        cfg_inc   = W'(inc);
        #1;
        ready_s = cfg_ready;
        if (model_valid) begin
            exp_ready = (chan >= CH) ? 1'b1 : !m_pend[chan];
            check("model_ready", 32'(ready_s), 32'(exp_ready));
        end
        @(posedge clk);
        #1;
        model_step(rst != 0, sync != 0, valid != 0, chan, inc);
        if (rst != 0) model_valid = 1'b1;
        if (model_valid) begin
`ifdef FRAC_CLK_SQUARE_EN
            exp_sq = m_sq;
`else
            exp_sq = '0;
`endif
            check("model_ce", 32'(ce), 32'(m_ce));
            check("model_locked", 32'(locked), 32'(m_locked));
            check("model_clk_sq", 32'(clk_sq), 32'(exp_sq));
        end
    endtask

    task automatic do_reset();
        repeat (2) cycle(1, 0, 0, 0, 0);
    endtask

    function automatic vec_t mk(int sync, int valid, int chan, int inc, int rdy, int ce_e, int lk);
        vec_t v;
        v.sync = sync; v.valid = valid; v.chan = chan; v.inc = inc;
        v.exp_ready = rdy; v.exp_ce = ce_e; v.exp_locked = lk;
        return v;
    endfunction

    // Safety net: the stimulus is bounded, this only fires on a stuck simulation.
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_k;
        int last_k;
        int pulses;
        int first0;
        int first1;
        int gaps[$];

        rst_n = 1'b0; sync_req = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_inc = '0;

        // ch0 inc=64: ce every 4th cycle, then retune to 128 mid-period.
        tbl[0]  = mk(0, 1, 0, 64,  1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0,   0, 0, 1);
        tbl[2]  = mk(0, 0, 0, 0,   1, 0, 1);
        tbl[3]  = mk(0, 0, 0, 0,   1, 0, 1);
        tbl[4]  = mk(0, 0, 0, 0,   1, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0,   1, 1, 1);
        tbl[6]  = mk(0, 0, 0, 0,   1, 0, 1);
        tbl[7]  = mk(0, 0, 0, 0,   1, 0, 1);
        tbl[8]  = mk(0, 0, 0, 0,   1, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0,   1, 1, 1);
        tbl[10] = mk(0, 0, 0, 0,   1, 0, 1);
        tbl[11] = mk(0, 0, 0, 0,   1, 0, 1);
        tbl[12] = mk(0, 0, 0, 0,   1, 0, 1);
        tbl[13] = mk(0, 0, 0, 0,   1, 1, 1);
        tbl[14] = mk(0, 1, 0, 128, 1, 0, 0);
        tbl[15] = mk(0, 0, 0, 0,   0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0,   0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0,   0, 1, 1);
        tbl[18] = mk(0, 0, 0, 0,   1, 0, 1);
        tbl[19] = mk(0, 0, 0, 0,   1, 1, 1);
        tbl[20] = mk(0, 0, 0, 0,   1, 0, 1);
        tbl[21] = mk(0, 0, 0, 0,   1, 1, 1);

        // Reset values and cfg_ready during reset.
        do_reset();
        check("reset_ce", 32'(ce), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_clk_sq", 32'(clk_sq), 32'd0);
        check("reset_ready", 32'(ready_s), 32'd1);

        for (int i = 0; i < NV; i++) begin
            cycle(0, tbl[i].sync, tbl[i].valid, tbl[i].chan, tbl[i].inc);
            check($sformatf("vec%0d_ready", i), 32'(ready_s), 32'(tbl[i].exp_ready));
            check($sformatf("vec%0d_ce", i), 32'(ce), 32'(tbl[i].exp_ce));
            check($sformatf("vec%0d_locked", i), 32'(locked), 32'(tbl[i].exp_locked));
        end

        // inc=96: first pulse 4 cycles after the write, gaps 3,2,3 repeating, 14 pulses in 40 cycles.
        do_reset();
        cycle(0, 0, 1, 0, 96);
        first_k = -1; last_k = -1; pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle(0, 0, 0, 0, 0);
            if (ce[0]) begin
                pulses++;
                if (last_k >= 0) gaps.push_back(k - last_k);
                else first_k = k;
                last_k = k;
            end
        end
        check("inc96_first", 32'(first_k), 32'd4);
        check("inc96_pulses", 32'(pulses), 32'd14);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("inc96_gap%0d", i), 32'(gaps.size() > i ? gaps[i] : -1),
                  32'((i % 3 == 1) ? 2 : 3));
        end

        // sync_req on a cycle where ch0 would carry: no ce, then first ce 4 (ch0) and 8 (ch1) later.
        do_reset();
        cycle(0, 0, 1, 0, 64);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 32);
        repeat (5) cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("sync_no_ce", 32'(ce), 32'd0);
        check("sync_locked", 32'(locked), 32'd3);
        first0 = -1; first1 = -1;
        for (int k = 1; k <= 12; k++) begin
            cycle(0, 0, 0, 0, 0);
            if (ce[0] && first0 < 0) first0 = k;
            if (ce[1] && first1 < 0) first1 = k;
        end
        check("sync_first_ce0", 32'(first0), 32'd4);
        check("sync_first_ce1", 32'(first1), 32'd8);
        // sync_req also promotes a pending increment at once.
        cycle(0, 0, 1, 0, 128);
        check("sync_pend_locked", 32'(locked[0]), 32'd0);
        cycle(0, 1, 0, 0, 0);
        check("sync_promote_locked", 32'(locked[0]), 32'd1);
        cycle(0, 0, 0, 0, 0);
        check("sync_promote_ce_a", 32'(ce[0]), 32'd0);
        cycle(0, 0, 0, 0, 0);
        check("sync_promote_ce_b", 32'(ce[0]), 32'd1);

        // Write to unmapped channel 5, then a write landing on a ch0 carry cycle.
        do_reset();
        cycle(0, 0, 1, 0, 64);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 5, 200);
        check("chan5_ready", 32'(ready_s), 32'd1);
        check("chan5_locked", 32'(locked), 32'd1);
        cycle(0, 0, 0, 1, 0);
        check("chan5_ch1_ready", 32'(ready_s), 32'd1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 128);
        check("carrywr_ready", 32'(ready_s), 32'd1);
        check("carrywr_ce", 32'(ce), 32'd1);
        check("carrywr_locked", 32'(locked), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 0);
            check("carrywr_wait_ready", 32'(ready_s), 32'd0);
            check("carrywr_wait_ce", 32'(ce), 32'd0);
            check("carrywr_wait_locked", 32'(locked), 32'd0);
        end
        cycle(0, 0, 0, 0, 0);
        check("carrywr_apply_ce", 32'(ce), 32'd1);
        check("carrywr_apply_locked", 32'(locked), 32'd1);
        cycle(0, 0, 0, 0, 0);
        check("carrywr_next_ce0", 32'(ce), 32'd0);
        cycle(0, 0, 0, 0, 0);
        check("carrywr_next_ce1", 32'(ce), 32'd1);

        // Reset while a write is pending: pending is discarded, channel stays idle.
        do_reset();
        cycle(0, 0, 1, 0, 64);
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 128);
        check("rstpend_locked", 32'(locked), 32'd0);
        cycle(1, 0, 0, 0, 0);
        check("rstpend_ce", 32'(ce), 32'd0);
        check("rstpend_locked_rst", 32'(locked), 32'd0);
        check("rstpend_clk_sq", 32'(clk_sq), 32'd0);
        cycle(1, 0, 0, 0, 0);
        check("rstpend_ready", 32'(ready_s), 32'd1);
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 0, 0, 0);
            check("rstrel_ready", 32'(ready_s), 32'd1);
            check("rstrel_ce", 32'(ce), 32'd0);
            check("rstrel_locked", 32'(locked), 32'd0);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            int r_rst, r_sync, r_valid, r_chan, r_inc;
            r_rst   = ($urandom_range(0, 399) == 0);
            r_sync  = ($urandom_range(0, 49) == 0);
            r_valid = ($urandom_range(0, 2) == 0);
            r_chan  = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 7) : $urandom_range(0, 1);
            r_inc   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MOD - 1);
            cycle(r_rst, r_sync, r_valid, r_chan, r_inc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
